dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
Controller for the 8-line x 8-bit direct-mapped cache data array (cache_mem). It owns the tag and valid state, and sequences CPU read/write requests against the data array. Misses are serviced from backing memory over a req/ack handshake. Policy is write-through with no write-allocate; read misses allocate. The block sits between the CPU load/store port and the main-memory interface.

Parameters:
ADDR_W, 8, CPU/memory byte address width; TAG_W = ADDR_W-3 (derived; index is fixed at 3 bits to match the 8-line array)
DATA_W, 8, data width; must equal the data array width
CNT_W, 16, width of the hit/miss statistics counters

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  request; held by CPU until cpu_ready
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  ADDR_W  byte address; index=[2:0], tag=[ADDR_W-1:3]
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
flush  in  1  invalidate all lines (honoured only in IDLE)
dm_addr  out  3  data array index
dm_wr  out  1  data array write strobe (array writes on negedge)
dm_rd  out  1  data array read strobe (array registers r_data on posedge)
dm_wdata  out  DATA_W  data array write data
dm_rdata  in  DATA_W  data array registered read data
mem_req  out  1  backing memory request; held until mem_ack
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  one-cycle acknowledge
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset (async): state=IDLE. Valid bits, tags, cpu_rdata, cpu_ready, counters, mem_req, dm_wr and dm_rd all go to 0. Any memory transaction in flight is abandoned immediately.
- States: IDLE, LOOKUP, HIT, MEM_RD, FILL, MEM_WR, DONE. Cycle 0 ends with the accept edge.
- IDLE: when flush=1, all valid bits clear at the next edge and the state stays IDLE. flush has priority over cpu_req; a held cpu_req is accepted on the following edge. Otherwise, cpu_req=1 latches we/addr/wdata and moves to LOOKUP.
- LOOKUP (cycle 1): hit = valid[idx] & tag[idx]==latched tag. dm_addr=idx throughout.
  - Read: dm_rd=1. Hit -> HIT. Miss -> MEM_RD.
  - Write: dm_wr=hit, dm_wdata=latched wdata. Next state MEM_WR.
  - Counters: hit_cnt or miss_cnt increments at the exiting edge; each saturates at all-ones.
- HIT: cpu_rdata<=dm_rdata; next state DONE. Read-hit completion therefore has cpu_ready high in cycle 3.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr. On an edge with mem_ack=1: capture mem_rdata into cpu_rdata, then go to FILL.
- FILL: dm_wr=1, dm_wdata=captured data. At the edge: tag[idx]<=tag, valid[idx]<=1; next state DONE. Read miss with zero-wait ack: cpu_ready in cycle 4.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata. On mem_ack go to DONE. A write miss leaves tag and valid unchanged. Write with zero-wait ack: cpu_ready in cycle 3.
- DONE: cpu_ready=1 for exactly one cycle, then IDLE. cpu_rdata holds until the next read completes.
- mem_req is held constant, along with mem_we, mem_addr and mem_wdata, from assertion until the ack edge. mem_ack in any other state is ignored.
- cpu_req is ignored outside IDLE. flush outside IDLE is ignored (not queued).
- Only one outstanding transaction at a time; no overlap between CPU and memory phases.

Test Plan:
- Reset, then read 0x2A (memory returns 0x5C after 2 wait cycles) -> mem_req with addr 0x2A; FILL writes 0x5C to index 2; cpu_ready with cpu_rdata=0x5C; miss_cnt=1.
- Re-read 0x2A -> no mem_req; cpu_ready in cycle 3 with 0x5C; hit_cnt=1.
- Write 0x2A=0x77 (hit), then read 0x2A -> dm_wr in LOOKUP; memory write to 0x2A; read returns 0x77 as a hit.
- Read 0x32 (same index 2, different tag) -> miss, refill; a later read of 0x2A misses again. Write to uncached 0x40 -> memory write only; valid[0] stays 0.
- flush and cpu_req asserted together in IDLE -> all lines invalid; the request is accepted one cycle later and misses.
- rst asserted during MEM_RD -> mem_req drops asynchronously; no cpu_ready; counters=0; a subsequent read misses.
- Drive hit_cnt to all-ones (CNT_W=4 build), then one more hit -> hit_cnt stays at 4'hF.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: owns tag/valid state for an 8-line data array and sequences
// CPU reads/writes against it, write-through with no write-allocate, read-miss allocate.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic [2:0]        dm_addr,
  output logic              dm_wr,
  output logic              dm_rd,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int unsigned TAG_W = ADDR_W - 3;

  typedef enum logic [2:0] {
    StIdle, StLookup, StHit, StMemRd, StFill, StMemWr, StDone
  } state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        valid_q;
  logic [TAG_W-1:0]  tag_q [8];
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  logic [2:0]        idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;

  assign idx = addr_q[2:0];
  assign tag = addr_q[ADDR_W-1:3];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  assign dm_addr   = idx;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // Strobes and mem_req decode from state alone, so reset drops them without waiting for an edge.
  always_comb begin
    state_d   = state_q;
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    dm_wdata  = wdata_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    cpu_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!flush && cpu_req) state_d = StLookup;
      end
      StLookup: begin
        if (we_q) begin
          dm_wr   = hit;
          state_d = StMemWr;
        end else begin
          dm_rd   = 1'b1;
          state_d = hit ? StHit : StMemRd;
        end
      end
      StHit: state_d = StDone;
      StMemRd: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = StFill;
      end
      StFill: begin
        dm_wr    = 1'b1;
        dm_wdata = rdata_q;
        state_d  = StDone;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = StDone;
      end
      StDone: begin
        cpu_ready = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < 8; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        if (flush) begin
          valid_q <= '0;
        end else if (cpu_req) begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end
      end
      if (state_q == StLookup) begin
        if (hit) begin
          if (~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end else begin
          if (~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
      end
      if (state_q == StHit) rdata_q <= dm_rdata;
      if (state_q == StMemRd && mem_ack) rdata_q <= mem_rdata;
      if (state_q == StFill) begin
        tag_q[idx]   <= tag;
        valid_q[idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomised self-checking bench for dm_cache_ctrl, with models of the data array and the
// backing memory; expectations come from cache-level rules (valid/tag per line, write-through).
module tb_dm_cache_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, flush;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready;
  logic [2:0]    dm_addr;
  logic          dm_wr, dm_rd;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dm_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .flush    (flush),
    .dm_addr  (dm_addr),
    .dm_wr    (dm_wr),
    .dm_rd    (dm_rd),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  // Data array: registered read on posedge, write on negedge.
  logic [DW-1:0] arr [8];
  always @(posedge clk) if (dm_rd) dm_rdata <= arr[dm_addr];
  always @(negedge clk) if (dm_wr) arr[dm_addr] <= dm_wdata;

  // Reference state: backing memory plus per-line residency.
  logic [DW-1:0] ref_mem [256];
  bit            ref_valid [8];
  logic [4:0]    ref_tag [8];
  int            ref_hits, ref_misses;
  logic [DW-1:0] last_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
    last_rdata = '0;
  endtask

  // Called at a negedge with the DUT idle; runs one complete CPU transaction.
  task automatic access(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                        input int waits, input bit do_flush);
    int            cyc, ready_cyc, mem_cycles, dmwr_cnt, exp_lat;
    bit            done, saw_mem, exp_hit;
    logic [2:0]    idx;
    logic [DW-1:0] rdata_at_ready;
    idx = addr[2:0];
    if (do_flush) for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    exp_hit   = ref_valid[idx] && (ref_tag[idx] == addr[7:3]);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    flush     = do_flush;
    if (do_flush) begin
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_no_lookup", {mem_req, dm_rd, dm_wr, cpu_ready}, 4'b0);
    end
    @(posedge clk);
    done = 0; saw_mem = 0; mem_cycles = 0; dmwr_cnt = 0; ready_cyc = 0; rdata_at_ready = '0;
    for (cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (dm_wr) dmwr_cnt++;
      if (mem_req) begin
        mem_cycles++;
        saw_mem = 1;
        check("mem_we_addr", {mem_we, mem_addr}, {we, addr});
        if (we) check("mem_wdata", mem_wdata, wd);
        if (mem_cycles == waits + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = ref_mem[addr];
          if (we) ref_mem[addr] = wd;
        end
      end
      if (cpu_ready) begin
        done           = 1;
        ready_cyc      = cyc;
        rdata_at_ready = cpu_rdata;
        cpu_req        = 1'b0;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("ready_pulse", cpu_ready, 0);
    exp_lat = we ? 3 + waits : (exp_hit ? 3 : 4 + waits);
    check("timeout", done, 1);
    check("latency", ready_cyc, exp_lat);
    check("mem_used", saw_mem, (we || !exp_hit));
    check("dm_wr_cnt", dmwr_cnt, we ? exp_hit : !exp_hit);
    if (!we) begin
      check("rdata", rdata_at_ready, ref_mem[addr]);
      last_rdata = ref_mem[addr];
    end else begin
      check("rdata_hold", rdata_at_ready, last_rdata);
    end
    if (exp_hit) begin
      if (ref_hits < 15) ref_hits++;
    end else begin
      if (ref_misses < 15) ref_misses++;
    end
    if (!we && !exp_hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = addr[7:3];
    end
    check("hit_cnt", hit_cnt, ref_hits);
    check("miss_cnt", miss_cnt, ref_misses);
  endtask

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) ref_tag[i] = '0;
    ref_mem[8'h2A] = 8'h5C;
    model_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {cpu_ready, mem_req, dm_wr, dm_rd}, 4'b0);
    check("rst_counts", {hit_cnt, miss_cnt}, 8'h00);
    check("rst_rdata", cpu_rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    access(0, 8'h2A, 8'h00, 2, 0);
    check("fill_array", arr[2], 8'h5C);
    access(0, 8'h2A, 8'h00, 0, 0);
    access(1, 8'h2A, 8'h77, 1, 0);
    access(0, 8'h2A, 8'h00, 0, 0);
    check("write_hit_data", last_rdata, 8'h77);
    access(0, 8'h32, 8'h00, 0, 0);
    access(0, 8'h2A, 8'h00, 1, 0);
    access(1, 8'h40, 8'h99, 0, 0);
    access(0, 8'h40, 8'h00, 0, 0);
    access(0, 8'h2A, 8'h00, 0, 1);

    // Reset while a read miss is waiting on memory.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h77;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1);
    #2 rst = 1'b1;
    #1 check("rst_async_mem_req", mem_req, 0);
    cpu_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mid_outputs", {cpu_ready, mem_req}, 2'b0);
    check("rst_mid_counts", {hit_cnt, miss_cnt}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    access(0, 8'h2A, 8'h00, 0, 0);

    repeat (17) access(0, 8'h2A, 8'h00, 0, 0);
    check("hit_saturated", hit_cnt, 4'hF);

    for (int n = 0; n < 60; n++) begin
      a = {5'($urandom_range(0, 2)), 3'($urandom_range(0, 7))};
      access(($urandom_range(0, 3) == 0), a, 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
